// File: rtl/inst_mem_reader.sv
// Instruction-side RAM read engine: wins the byte-wide bus, fetches a 2- or 4-byte
// little-endian instruction at the latched pc and presents it until consumed.
module inst_mem_reader #(
  parameter int XLEN    = 32,
  parameter int RAM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            stall,
  input  logic            fet_req,
  input  logic [XLEN-1:0] fet_pc,
  input  logic            bus_grant,
  input  logic [7:0]      ram_din,
  output logic            bus_req,
  output logic [XLEN-1:0] ram_a,
  output logic            mem_inst_ready,
  output logic [XLEN-1:0] mem_inst,
  output logic [XLEN-1:0] mem_inst_addr,
  output logic [1:0]      state_dbg
);

  // Handshake: mem_inst_ready is a valid that stays high (with mem_inst and
  // mem_inst_addr stable) until a cycle with stall low, which acts as ready.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, READ = 2'd2, DONE = 2'd3} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] base, base_nxt;
  logic [XLEN-1:0] ram_a_nxt, inst_nxt, addr_nxt;
  logic [31:0]     ibuf, ibuf_nxt, ibuf_cap;
  logic [2:0]      cnt, cnt_nxt, cap_idx, last_cnt, n_bytes;
  logic            is_full, is_full_nxt, len4;
  logic            bus_req_nxt, ready_nxt;

  assign state_dbg = state;

  always_comb begin
    // Length is known from byte0 the cycle it arrives; later cycles use the stored flag.
    len4     = (cnt == 3'(RAM_LAT)) ? (ram_din[1:0] == 2'b11) : is_full;
    n_bytes  = len4 ? 3'd4 : 3'd2;
    last_cnt = len4 ? 3'(3 + RAM_LAT) : 3'(1 + RAM_LAT);
    cap_idx  = cnt - 3'(RAM_LAT);
    ibuf_cap = ibuf;
    if (cnt >= 3'(RAM_LAT)) begin
      case (cap_idx)
        3'd0:    ibuf_cap[7:0]   = ram_din;
        3'd1:    ibuf_cap[15:8]  = ram_din;
        3'd2:    ibuf_cap[23:16] = ram_din;
        3'd3:    ibuf_cap[31:24] = ram_din;
        default: ibuf_cap        = ibuf;
      endcase
    end

    state_nxt   = state;
    base_nxt    = base;
    ram_a_nxt   = ram_a;
    inst_nxt    = mem_inst;
    addr_nxt    = mem_inst_addr;
    ibuf_nxt    = ibuf;
    cnt_nxt     = cnt;
    is_full_nxt = is_full;
    bus_req_nxt = bus_req;
    ready_nxt   = mem_inst_ready;

    if (rdy) begin
      case (state)
        IDLE: begin
          if (fet_req && !flush && !mem_inst_ready) begin
            base_nxt    = fet_pc;
            bus_req_nxt = 1'b1;
            state_nxt   = WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            state_nxt   = IDLE;
            bus_req_nxt = 1'b0;
            ram_a_nxt   = '0;
          end else if (bus_grant) begin
            state_nxt = READ;
            cnt_nxt   = 3'd0;
            ram_a_nxt = base;
          end
        end
        READ: begin
          if (flush) begin
            state_nxt   = IDLE;
            bus_req_nxt = 1'b0;
            ram_a_nxt   = '0;
          end else begin
            ibuf_nxt    = ibuf_cap;
            is_full_nxt = len4;
            cnt_nxt     = cnt + 3'd1;
            if (cnt == last_cnt) begin
              state_nxt = DONE;
              ready_nxt = 1'b1;
              inst_nxt  = len4 ? XLEN'(ibuf_cap) : XLEN'(ibuf_cap[15:0]);
              addr_nxt  = base;
            end else if (cnt + 3'd1 < n_bytes) begin
              ram_a_nxt = base + XLEN'(cnt) + XLEN'(1);
            end else begin
              // Last address already issued: release the bus while the final byte lands.
              ram_a_nxt   = '0;
              bus_req_nxt = 1'b0;
            end
          end
        end
        DONE: begin
          if (flush || !stall) begin
            ready_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      base           <= '0;
      ram_a          <= '0;
      mem_inst       <= '0;
      mem_inst_addr  <= '0;
      ibuf           <= '0;
      cnt            <= 3'd0;
      is_full        <= 1'b0;
      bus_req        <= 1'b0;
      mem_inst_ready <= 1'b0;
    end else begin
      state          <= state_nxt;
      base           <= base_nxt;
      ram_a          <= ram_a_nxt;
      mem_inst       <= inst_nxt;
      mem_inst_addr  <= addr_nxt;
      ibuf           <= ibuf_nxt;
      cnt            <= cnt_nxt;
      is_full        <= is_full_nxt;
      bus_req        <= bus_req_nxt;
      mem_inst_ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_inst_mem_reader.sv
// Bench for inst_mem_reader: directed table of fetches plus randomized fetches
// compared cycle by cycle against a transaction-level model of the expected bus trace.
module tb_inst_mem_reader;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, stall, fet_req, bus_grant;
  logic [31:0] fet_pc;
  logic [7:0]  ram_din = 8'h00;
  logic        bus_req, mem_inst_ready;
  logic [31:0] ram_a, mem_inst, mem_inst_addr;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;
  bit freeze_en = 0;

  always #5 clk = ~clk;

  inst_mem_reader #(.XLEN(32), .RAM_LAT(1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .stall(stall),
    .fet_req(fet_req), .fet_pc(fet_pc), .bus_grant(bus_grant), .ram_din(ram_din),
    .bus_req(bus_req), .ram_a(ram_a), .mem_inst_ready(mem_inst_ready),
    .mem_inst(mem_inst), .mem_inst_addr(mem_inst_addr), .state_dbg(state_dbg)
  );

  // Byte RAM with one cycle read latency; shares the global enable.
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge clk) if (rdy) ram_din <= ram_byte(ram_a);

  // Reference model: instruction length and value from the RAM contents.
  function automatic int model_len(input logic [31:0] pc);
    logic [7:0] b0;
    b0 = ram_byte(pc);
    return (b0[1:0] == 2'b11) ? 4 : 2;
  endfunction

  function automatic logic [31:0] model_inst(input logic [31:0] pc);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = model_len(pc);
    for (int i = 0; i < n; i++) v = v | (32'(ram_byte(pc + 32'(i))) << (8 * i));
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare(input logic eb, input logic [31:0] ea, input logic er,
                         input logic [31:0] ei, input logic [31:0] ead);
    chk("bus_req", 32'(bus_req), 32'(eb));
    chk("ram_a", ram_a, ea);
    chk("mem_inst_ready", 32'(mem_inst_ready), 32'(er));
    if (er) begin
      chk("mem_inst", mem_inst, ei);
      chk("mem_inst_addr", mem_inst_addr, ead);
    end
  endtask

  // One cycle: optional rdy-low freeze cycles (outputs must hold), then a normal cycle.
  task automatic step(input logic eb, input logic [31:0] ea, input logic er,
                      input logic [31:0] ei, input logic [31:0] ead);
    logic sv_req, sv_fl, sv_st;
    if (freeze_en && $urandom_range(0, 7) == 0) begin
      sv_req = fet_req; sv_fl = flush; sv_st = stall;
      rdy = 1'b0;
      for (int j = 0; j < int'($urandom_range(1, 2)); j++) begin
        fet_req = 1'($urandom); flush = 1'($urandom); stall = 1'($urandom);
        @(negedge clk);
        compare(eb, ea, er, ei, ead);
        @(posedge clk); #1;
      end
      fet_req = sv_req; flush = sv_fl; stall = sv_st;
      rdy = 1'b1;
    end
    @(negedge clk);
    compare(eb, ea, er, ei, ead);
    @(posedge clk); #1;
  endtask

  // flush_at counts cycles from the first WAIT cycle; -1 means no flush.
  task automatic run_txn(input logic [31:0] pc, input int n, input logic [31:0] exp_inst,
                         input int gdelay, input int nstall, input int flush_at);
    int t;
    bit fl;
    t = 0; fl = 0;
    fet_req = 1'b1; fet_pc = pc; flush = 1'b0;
    stall = 1'($urandom); bus_grant = 1'($urandom);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i <= gdelay && !fl; i++) begin
      fet_req = 1'($urandom); fet_pc = $urandom; stall = 1'($urandom);
      bus_grant = (i == gdelay);
      flush = (t == flush_at); fl = flush;
      step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      t++;
    end
    for (int k = 0; k <= n && !fl; k++) begin
      fet_req = 1'($urandom); fet_pc = $urandom; stall = 1'($urandom);
      bus_grant = (k < n);
      flush = (t == flush_at); fl = flush;
      step(k < n, (k < n) ? pc + 32'(k) : 32'h0, 1'b0, 32'h0, 32'h0);
      t++;
    end
    for (int s = 0; s <= nstall && !fl; s++) begin
      fet_req = 1'($urandom); fet_pc = $urandom; bus_grant = 1'($urandom);
      stall = (s < nstall);
      flush = (t == flush_at); fl = flush;
      step(1'b0, 32'h0, 1'b1, exp_inst, pc);
      t++;
    end
    fet_req = 1'b0; flush = 1'b0; bus_grant = 1'($urandom); stall = 1'($urandom);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  b0, b1, b2, b3;
    int          gdelay, nstall, flush_at;
    int          exp_len;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] pc;
    int gd, ns, fa, n;

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; stall = 1'b0; fet_req = 1'b0;
    fet_pc = 32'h0; bus_grant = 1'b0;

    vecs[0] = '{32'h0000_0100, 8'h01, 8'h45, 8'h00, 8'h00, 0, 0, -1, 2, 32'h0000_4501};
    vecs[1] = '{32'h0000_0200, 8'h93, 8'h00, 8'h10, 8'h00, 0, 0, -1, 4, 32'h0010_0093};
    vecs[2] = '{32'h0000_0200, 8'h93, 8'h00, 8'h10, 8'h00, 3, 0, -1, 4, 32'h0010_0093};
    vecs[3] = '{32'h0000_0280, 8'h13, 8'h05, 8'hA0, 8'h00, 0, 0,  3, 4, 32'h00A0_0513};
    vecs[4] = '{32'h0000_0300, 8'h37, 8'h41, 8'h00, 8'h00, 0, 0, -1, 4, 32'h0000_4137};
    vecs[5] = '{32'h0000_0400, 8'h82, 8'h80, 8'h11, 8'h22, 1, 4, -1, 2, 32'h0000_8082};
    vecs[6] = '{32'hFFFF_FFFE, 8'h13, 8'h01, 8'h01, 8'hFF, 0, 0, -1, 4, 32'hFF01_0113};
    vecs[7] = '{32'h0000_0500, 8'h05, 8'h46, 8'h00, 8'h00, 0, 3,  5, 2, 32'h0000_4605};
    vecs[8] = '{32'h0000_0600, 8'h93, 8'h80, 8'h10, 8'h00, 2, 0,  1, 4, 32'h0010_8093};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    compare(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("rst_mem_inst", mem_inst, 32'h0);
    chk("rst_mem_inst_addr", mem_inst_addr, 32'h0);
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // flush beats a same-cycle request; grant without request is ignored
    fet_req = 1'b1; fet_pc = 32'h0000_0100; flush = 1'b1; bus_grant = 1'b1;
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    fet_req = 1'b0; flush = 1'b0;
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    // request while rdy low is not taken
    rdy = 1'b0; fet_req = 1'b1;
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rdy = 1'b1; fet_req = 1'b0; bus_grant = 1'b0;
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Directed table
    for (int v = 0; v < 9; v++) begin
      mem[vecs[v].pc]          = vecs[v].b0;
      mem[vecs[v].pc + 32'd1]  = vecs[v].b1;
      mem[vecs[v].pc + 32'd2]  = vecs[v].b2;
      mem[vecs[v].pc + 32'd3]  = vecs[v].b3;
      run_txn(vecs[v].pc, vecs[v].exp_len, vecs[v].exp_inst,
              vecs[v].gdelay, vecs[v].nstall, vecs[v].flush_at);
    end

    // Async reset in the middle of a wrapping read
    fet_req = 1'b1; fet_pc = 32'hFFFF_FFFE;
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    fet_req = 1'b0; bus_grant = 1'b1;
    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'h0);
    #2;
    chk("pre_rst_ram_a", ram_a, 32'hFFFF_FFFF);
    rst = 1'b1;
    #1;
    chk("async_rst_bus_req", 32'(bus_req), 32'h0);
    chk("async_rst_ram_a", ram_a, 32'h0);
    chk("async_rst_ready", 32'(mem_inst_ready), 32'h0);
    chk("async_rst_mem_inst", mem_inst, 32'h0);
    chk("async_rst_mem_inst_addr", mem_inst_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; bus_grant = 1'b0;
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Randomized fetches with rdy freezes, stalls, grant delays and flushes
    freeze_en = 1;
    for (int r = 0; r < 60; r++) begin
      pc = $urandom;
      pc[0] = 1'b0;
      if (r % 10 == 9) pc = 32'hFFFF_FFFE - 32'(2 * (r % 3));
      for (int i = 0; i < 4; i++) mem[pc + 32'(i)] = 8'($urandom_range(0, 255));
      n  = model_len(pc);
      gd = $urandom_range(0, 3);
      ns = $urandom_range(0, 3);
      fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, gd + n + 2 + ns)) : -1;
      run_txn(pc, n, model_inst(pc), gd, ns, fa);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        fet_req = 1'b0; flush = 1'($urandom); bus_grant = 1'($urandom);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      end
      flush = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
